mem_arbiter_mp: RTL
===================

MEM_ARBITER_MP -- requirements
Module: mem_arbiter_mp

Interface
REQ-001 Parameter NUM_PORTS, default 2, number of requesting clients; port 0 is the LSB and port 1 the ICache in the core.
REQ-002 Parameter MAX_BYTES, default 4, largest transfer in bytes; LW = clog2(MAX_BYTES+1).
REQ-003 Parameter RD_LAT, default 1, RAM read latency in cycles from mem_a to valid mem_din.
REQ-004 Parameter IO_BASE, default 32'h0003_0000; addresses at or above it are IO.
REQ-005 Parameter FLUSHABLE, default NUM_PORTS'b10, per-port mask of ports whose reads are aborted by flush_in.
REQ-006 One clock; reset is synchronous and active-low.
REQ-007 Port clk_in, input, 1: clock, all state changes on its rising edge.
REQ-008 Port rst_n_in, input, 1: synchronous active-low reset.
REQ-009 Port rdy_in, input, 1: when low, every register holds its value.
REQ-010 mem_din in 8 (RAM read byte); mem_dout out 8; mem_a out 32; mem_wr out 1 (1 = write); io_buffer_full in 1.
REQ-011 req_valid in NUM_PORTS; req_we in NUM_PORTS; req_len in NUM_PORTS*LW (bytes, 0..MAX_BYTES); req_sext in NUM_PORTS; req_addr in NUM_PORTS*32; req_wdata in NUM_PORTS*MAX_BYTES*8.
REQ-012 resp_valid out NUM_PORTS (one-cycle pulse per port); resp_rdata out MAX_BYTES*8 (shared, valid with any pulse); flush_in in 1.

Function
REQ-013 A request is level: the client holds req_* stable from assertion until the edge after its resp_valid pulse.
REQ-014 States: IDLE, READ, WRITE; controller serves one request at a time.
REQ-015 In IDLE, arbitration is round-robin starting at the port after the last granted port; the initial pointer after reset selects port 0 first.
REQ-016 Ineligible in IDLE: a port pulsed resp_valid this cycle; an IO-address request while io_buffer_full=1; a FLUSHABLE port while flush_in=1.
REQ-017 Grant edge E0: mem_a = addr, byte 0 presented; byte k presented at edge E0+k; mem_a increments modulo 2^32.
REQ-018 Write: mem_wr=1 and mem_dout = wdata[8k+7:8k] for byte k; at edge E0+L, mem_wr=0, mem_a=0, resp pulse, return to IDLE.
REQ-019 Read: mem_wr=0; byte k is captured from mem_din at edge E0+k+RD_LAT into rdata[8k+7:8k].
REQ-019a Read completion: at edge E0+L-1+RD_LAT, the last byte is captured, resp pulses, and the controller returns to IDLE.
REQ-020 Read result: bits above 8L are filled with bit 8L-1 if req_sext, else with zero.
REQ-021 req_len=0: no RAM access; resp pulses at E0+1 with resp_rdata=0.
REQ-022 Back-to-back: a new grant is allowed in the IDLE cycle immediately following completion; no idle bubble beyond REQ-016.
REQ-023 flush_in=1 during READ of a FLUSHABLE port: abort at that edge, no resp, mem_a=0, state IDLE; stale mem_din is ignored.
REQ-024 Writes and reads of non-FLUSHABLE ports are never aborted.
REQ-025 rdy_in=0 freezes counters, outputs and the pipeline; RAM latency counting resumes on rdy_in=1.

Reset
REQ-026 On rst_n_in=0: state IDLE; mem_a=0, mem_dout=0, mem_wr=0, resp_valid=0, resp_rdata=0; RR pointer selects port 0 first; counters 0.
REQ-027 Reset mid-transfer drops the transfer with no resp and no further mem_wr.

Structure
REQ-028 Package mem_pkg holds the state enum, IO_BASE default and an LW width function.
REQ-029 Sub-module rr_arbiter (NUM_PORTS request mask in, one-hot grant out, pointer update on accept) is instantiated once.

Verification
REQ-030 Port 0 write, L=4, addr 0x100, data 0xDEADBEEF -> mem_wr=1 with bytes EF,BE,AD,DE at 0x100..0x103; resp_valid[0] at E0+4.
REQ-031 Read, L=1, sext=1, RAM byte 0x80, RD_LAT=1 -> resp_rdata=0xFFFFFF80 at E0+1; sext=0 -> 0x00000080.
REQ-032 Both ports request continuously -> grants alternate 0,1,0,1; neither port is starved.
REQ-033 Port 1 read, L=4; flush_in at E0+2 -> no resp_valid[1]; next grant goes to pending port 0 on the following cycle.
REQ-034 Port 0 write to 0x30000 with io_buffer_full=1 and port 1 valid -> port 1 is served first; port 0 is granted once full=0.
REQ-035 rdy_in low for 3 cycles mid-read -> completes with correct data, delayed by exactly 3 cycles.

Source files
------------

// File: rtl/mem_pkg.sv
// ----------------------------------------------------------------------------
// mem_pkg
// Shared definitions for the multi-port memory arbiter:
//   state_t          controller states (IDLE, READ, WRITE)
//   IO_BASE_DEFAULT  first address treated as memory-mapped IO
//   lw_width()       width of a byte-count field able to hold 0..max_bytes
// ----------------------------------------------------------------------------
package mem_pkg;

    localparam logic [31:0] IO_BASE_DEFAULT = 32'h0003_0000;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_WRITE = 2'd2
    } state_t;

    function automatic int lw_width(input int max_bytes);
        return $clog2(max_bytes + 1);
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// ----------------------------------------------------------------------------
// rr_arbiter
// Round-robin arbiter. The search starts at the port after the last accepted
// grant; after reset the pointer sits on the highest port so port 0 wins first.
// Ports:
//   clk_in    clock (rising edge)
//   rst_n_in  synchronous active-low reset
//   req       request mask, one bit per port
//   accept    the current grant was taken; move the pointer onto it
//   grant     one-hot grant (all zero when no request)
// ----------------------------------------------------------------------------
module rr_arbiter #(
    parameter int N = 2
) (
    input  logic         clk_in,
    input  logic         rst_n_in,
    input  logic [N-1:0] req,
    input  logic         accept,
    output logic [N-1:0] grant
);

    localparam int IW = (N > 1) ? $clog2(N) : 1;

    logic [IW-1:0] last_idx;

    // Scan the ports in rotating order starting just after the last winner.
    always_comb begin
        int  idx;
        logic found;
        grant = '0;
        found = 1'b0;
        idx   = 0;
        for (int off = 1; off <= N; off++) begin
            idx = int'(last_idx) + off;
            if (idx >= N) begin
                idx = idx - N;
            end
            if (!found && req[idx]) begin
                grant[idx] = 1'b1;
                found      = 1'b1;
            end
        end
    end

    // Remember the winner only when the controller actually took the grant.
    always_ff @(posedge clk_in) begin
        if (!rst_n_in) begin
            last_idx <= IW'(N - 1);
        end else if (accept) begin
            for (int i = 0; i < N; i++) begin
                if (grant[i]) begin
                    last_idx <= IW'(i);
                end
            end
        end
    end

endmodule

// File: rtl/mem_arbiter_mp.sv
// ----------------------------------------------------------------------------
// mem_arbiter_mp
// Serialises byte-wide RAM accesses for several clients. One request is served
// at a time; each transfer moves req_len bytes (0..MAX_BYTES) starting at
// req_addr, one byte per cycle, and ends with a one-cycle resp_valid pulse on
// the owning port. Reads are assembled little-endian and optionally
// sign-extended. Reads of FLUSHABLE ports are abandoned when flush_in rises.
// Ports:
//   clk_in, rst_n_in     clock / synchronous active-low reset
//   rdy_in               global enable; low freezes all state
//   mem_din              RAM read byte, valid RD_LAT cycles after mem_a
//   mem_dout, mem_a, mem_wr  RAM write byte, address, write strobe
//   io_buffer_full       IO sink cannot accept; IO requests wait
//   req_*                per-port level requests (packed, port 0 in LSBs)
//   resp_valid           per-port completion pulse
//   resp_rdata           read result shared by all ports
//   flush_in             pipeline flush; aborts reads of FLUSHABLE ports
// ----------------------------------------------------------------------------
module mem_arbiter_mp
    import mem_pkg::*;
#(
    parameter int                   NUM_PORTS = 2,
    parameter int                   MAX_BYTES = 4,
    parameter int                   RD_LAT    = 1,
    parameter logic [31:0]          IO_BASE   = IO_BASE_DEFAULT,
    parameter logic [NUM_PORTS-1:0] FLUSHABLE = NUM_PORTS'(2'b10),
    localparam int                  LW        = lw_width(MAX_BYTES),
    localparam int                  DW        = MAX_BYTES * 8
) (
    input  logic                    clk_in,
    input  logic                    rst_n_in,
    input  logic                    rdy_in,
    input  logic [7:0]              mem_din,
    output logic [7:0]              mem_dout,
    output logic [31:0]             mem_a,
    output logic                    mem_wr,
    input  logic                    io_buffer_full,
    input  logic [NUM_PORTS-1:0]    req_valid,
    input  logic [NUM_PORTS-1:0]    req_we,
    input  logic [NUM_PORTS*LW-1:0] req_len,
    input  logic [NUM_PORTS-1:0]    req_sext,
    input  logic [NUM_PORTS*32-1:0] req_addr,
    input  logic [NUM_PORTS*DW-1:0] req_wdata,
    output logic [NUM_PORTS-1:0]    resp_valid,
    output logic [DW-1:0]           resp_rdata,
    input  logic                    flush_in
);

    localparam int CW = $clog2(MAX_BYTES + RD_LAT + 1) + 1;

    state_t               state;
    logic [NUM_PORTS-1:0] elig;
    logic [NUM_PORTS-1:0] arb_req;
    logic [NUM_PORTS-1:0] grant;
    logic                 accept;

    logic                 sel_we;
    logic                 sel_sext;
    logic [LW-1:0]        sel_len;
    logic [31:0]          sel_addr;
    logic [DW-1:0]        sel_wdata;

    logic [NUM_PORTS-1:0] cur_port;
    logic                 cur_flush;
    logic [LW-1:0]        cur_len;
    logic                 cur_sext;
    logic [DW-1:0]        cur_wdata;

    // cnt = edges elapsed since the grant edge; step is the edge being taken.
    logic [CW-1:0]        cnt;
    logic [CW-1:0]        step;
    logic [CW-1:0]        cap_idx;
    logic                 cap_valid;
    logic                 last_cap;
    logic                 more_addr;
    logic [DW-1:0]        rd_buf;
    logic [DW-1:0]        cap_buf;
    logic [7:0]           wr_byte;

    // Keep the low len bytes and fill everything above with the sign of the
    // top kept byte (or zero). A zero length yields zero.
    function automatic logic [DW-1:0] extend(input logic [DW-1:0] d,
                                             input logic [LW-1:0] len,
                                             input logic          sext);
        logic [DW-1:0] r;
        logic          fill;
        r    = '0;
        fill = 1'b0;
        for (int b = 0; b < MAX_BYTES; b++) begin
            if (LW'(b + 1) == len) begin
                fill = sext & d[b*8+7];
            end
        end
        for (int b = 0; b < MAX_BYTES; b++) begin
            if (LW'(b) < len) begin
                r[b*8 +: 8] = d[b*8 +: 8];
            end else begin
                r[b*8 +: 8] = {8{fill}};
            end
        end
        return r;
    endfunction

    // A port may compete only if it is not just finishing, is not an IO
    // access blocked by a full buffer, and is not held off by a flush.
    always_comb begin
        elig = '0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            elig[i] = req_valid[i] && !resp_valid[i]
                      && !((req_addr[i*32 +: 32] >= IO_BASE) && io_buffer_full)
                      && !(FLUSHABLE[i] && flush_in);
        end
    end

    assign arb_req = (state == ST_IDLE) ? elig : '0;
    assign accept  = rdy_in && (state == ST_IDLE) && (|grant);

    rr_arbiter #(
        .N(NUM_PORTS)
    ) u_rr (
        .clk_in  (clk_in),
        .rst_n_in(rst_n_in),
        .req     (arb_req),
        .accept  (accept),
        .grant   (grant)
    );

    // Mux the winning port's request fields.
    always_comb begin
        sel_we    = 1'b0;
        sel_sext  = 1'b0;
        sel_len   = '0;
        sel_addr  = '0;
        sel_wdata = '0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            if (grant[i]) begin
                sel_we    = req_we[i];
                sel_sext  = req_sext[i];
                sel_len   = req_len[i*LW +: LW];
                sel_addr  = req_addr[i*32 +: 32];
                sel_wdata = req_wdata[i*DW +: DW];
            end
        end
    end

    // Byte k of a read returns RD_LAT edges after its address went out, so at
    // edge "step" the byte being captured is step-RD_LAT.
    assign step      = cnt + CW'(1);
    assign cap_valid = (step >= CW'(RD_LAT));
    assign cap_idx   = step - CW'(RD_LAT);
    assign last_cap  = cap_valid && (cap_idx == (CW'(cur_len) - CW'(1)));
    assign more_addr = (step < CW'(cur_len));

    always_comb begin
        cap_buf = rd_buf;
        wr_byte = '0;
        for (int b = 0; b < MAX_BYTES; b++) begin
            if (cap_valid && (cap_idx == CW'(b))) begin
                cap_buf[b*8 +: 8] = mem_din;
            end
            if (step == CW'(b)) begin
                wr_byte = cur_wdata[b*8 +: 8];
            end
        end
    end

    // Controller. Zero-length requests of either direction run through WRITE
    // with the strobe off: they touch no RAM and finish one edge later with
    // zero data, which is exactly the write completion path.
    always_ff @(posedge clk_in) begin
        if (!rst_n_in) begin
            state      <= ST_IDLE;
            mem_a      <= '0;
            mem_dout   <= '0;
            mem_wr     <= 1'b0;
            resp_valid <= '0;
            resp_rdata <= '0;
            cnt        <= '0;
            rd_buf     <= '0;
            cur_port   <= '0;
            cur_flush  <= 1'b0;
            cur_len    <= '0;
            cur_sext   <= 1'b0;
            cur_wdata  <= '0;
        end else if (rdy_in) begin
            resp_valid <= '0;
            case (state)
                ST_IDLE: begin
                    if (|grant) begin
                        cur_port  <= grant;
                        cur_flush <= |(grant & FLUSHABLE);
                        cur_len   <= sel_len;
                        cur_sext  <= sel_sext;
                        cur_wdata <= sel_wdata;
                        cnt       <= '0;
                        rd_buf    <= '0;
                        if (sel_len == '0) begin
                            state  <= ST_WRITE;
                            mem_wr <= 1'b0;
                            mem_a  <= '0;
                        end else if (sel_we) begin
                            state    <= ST_WRITE;
                            mem_wr   <= 1'b1;
                            mem_a    <= sel_addr;
                            mem_dout <= sel_wdata[7:0];
                        end else begin
                            state  <= ST_READ;
                            mem_wr <= 1'b0;
                            mem_a  <= sel_addr;
                        end
                    end
                end
                ST_WRITE: begin
                    cnt <= step;
                    if (step >= CW'(cur_len)) begin
                        mem_wr     <= 1'b0;
                        mem_a      <= '0;
                        resp_valid <= cur_port;
                        resp_rdata <= '0;
                        state      <= ST_IDLE;
                    end else begin
                        mem_a    <= mem_a + 32'd1;
                        mem_dout <= wr_byte;
                    end
                end
                ST_READ: begin
                    // A flush wins even over a completing read; bytes still
                    // in flight from the RAM are simply never looked at.
                    if (flush_in && cur_flush) begin
                        mem_a <= '0;
                        state <= ST_IDLE;
                    end else begin
                        cnt    <= step;
                        rd_buf <= cap_buf;
                        if (more_addr) begin
                            mem_a <= mem_a + 32'd1;
                        end
                        if (last_cap) begin
                            resp_valid <= cur_port;
                            resp_rdata <= extend(cap_buf, cur_len, cur_sext);
                            mem_a      <= '0;
                            state      <= ST_IDLE;
                        end
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
